top: RTL and testbench
======================

# top

Board-level top for the button-to-LED pipeline demonstrator. It samples push-button `BUT1` on `CLK` and drives two LEDs from two register chains of different depth. `LED1` uses a one-stage path, the behaviour of a chain whose intermediate register collapses. `LED2` uses a true multi-stage pipeline. It is the root of the design: pins in, pins out, no bus interfaces.

## Interface
- `DEPTH`, default 2: number of register stages on the `LED2` path; legal range 2..8.
- `LED_ACTIVE_LOW`, default 0: 1 inverts both LED outputs at the pin (lit = 0).
- `CLK` input 1: single system clock; all state updates on its rising edge.
- `RST_N` input 1: reset, asynchronous assert, active-low; clears every register.
- `BUT1` input 1: push-button level, 1 = pressed; treated as synchronous to `CLK` unless `BUT1_SYNC_EN` is defined.
- `LED1` output 1: button level delayed by 1 cycle.
- `LED2` output 1: button level delayed by `DEPTH` cycles.

## Operation
- Define `b` as the button sample: `BUT1` directly, or the output of the synchronizer when `BUT1_SYNC_EN` is defined.
- LED1 path: one register `r1` loads `b` on every rising edge. `LED1 = r1`, inverted when `LED_ACTIVE_LOW` is 1.
- LED2 path: a shift chain `s[0..DEPTH-1]`.
  - Every edge: `s[0] <= b` and `s[i] <= s[i-1]`.
  - All stages update concurrently from pre-edge values; no stage may see a same-edge value.
  - `LED2 = s[DEPTH-1]`, with the same inversion rule.
- No state machine, no arithmetic.
- Both paths are pure delay lines: every input pulse of at least one cycle reappears unchanged in width on each LED.
- While `RST_N` = 0:
  - all registers read 0;
  - LEDs are unlit: 0, or 1 when `LED_ACTIVE_LOW`.
- After `RST_N` deasserts, each output shows pre-reset history as 0 until its chain has refilled. `LED1` needs 1 edge; `LED2` needs `DEPTH` edges.
- Reset asserted mid-operation discards all in-flight pulses immediately, without waiting for a clock.

## Timing
- `LED1` latency: 1 rising edge from `b`.
- `LED2` latency: `DEPTH` rising edges from `b` (2 by default).
- `LED2` therefore lags `LED1` by exactly `DEPTH-1` cycles for every transition.
- `BUT1_SYNC_EN` adds 2 cycles to both latencies. The relative lag between the LEDs is unchanged.
- Outputs are registered (an inverter at most after the flop), so there is no combinational path from `BUT1` to either LED.
- Reset assertion is asynchronous. Deassertion is sampled at the next rising edge; the integrator supplies an externally synchronized release.

## Configuration
- Macro `BUT1_SYNC_EN`.
- Defined: a two-flop synchronizer, reset to 0, sits in front of both paths. The synchronizer is shared, so `LED1` and `LED2` always see the identical sample.
- Undefined: `b = BUT1` with no extra latency. This is the default build, used with synchronous stimulus.

## Structure
- Package `top_pkg` holds:
  - `LED_ON` / `LED_OFF` 1-bit constants, selected by `LED_ACTIVE_LOW`;
  - `DEPTH_MIN = 2` and `DEPTH_MAX = 8`;
  - a `DEPTH` range assertion.
- One sub-module, `pipe_reg`:
  - parameterised `N`-stage shift register with asynchronous active-low reset;
  - instantiated with N = 1 for `LED1`, N = `DEPTH` for `LED2`, and N = 2 as the optional synchronizer.

## Test plan
- Reset: hold `RST_N` = 0 with `BUT1` = 1 for 5 cycles -> `LED1` = `LED2` = 0 throughout. Release -> `LED1` = 1 after 1 edge, `LED2` = 1 after 2 edges.
- Periodic pulse, default build, CLK period 2 ns: `BUT1` high for one cycle out of every five, rising at 10 ns -> `LED1` high 11–13 ns, `LED2` high 13–15 ns, pattern repeating every 10 ns for 100 ns.
- Lag check: `DEPTH` = 4, single-cycle `BUT1` pulse -> `LED2` pulse exactly 3 cycles after `LED1`, both one cycle wide.
- Mid-operation reset: pulse in flight in `s[0]`, assert `RST_N` between edges -> both LEDs drop to 0 immediately, and the pulse never appears after release.
- `LED_ACTIVE_LOW` = 1: same stimulus as the periodic-pulse case -> both outputs idle at 1 and pulse to 0 at identical times.
- `BUT1_SYNC_EN` defined: single-cycle pulse -> `LED1` after 3 edges, `LED2` after 4 edges.

Source files
------------

// File: rtl/top_pkg.sv
// Shared constants and helpers for the button-to-LED demonstrator.
// Optional feature macro: BUT1_SYNC_EN (two-flop button synchronizer).
`timescale 1ns/1ps
package top_pkg;

  // Legal LED2 chain depth.
  localparam int DEPTH_MIN   = 2;
  localparam int DEPTH_MAX   = 8;

  // Number of flops in the optional button synchronizer.
  localparam int SYNC_STAGES = 2;

  // Pin level for a lit LED, selected by LED_ACTIVE_LOW.
  function automatic logic led_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  // Pin level for a dark LED, selected by LED_ACTIVE_LOW.
  function automatic logic led_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // True when the requested LED2 depth lies in the legal range.
  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/top_if.sv
// Pin bundle of the demonstrator: button in, two LEDs out.
// Optional feature macro: BUT1_SYNC_EN (no effect on this bundle).
`timescale 1ns/1ps
interface top_if;
  logic BUT1;
  logic LED1;
  logic LED2;

  // Board / stimulus side: drives the button, watches the LEDs.
  modport master (output BUT1, input LED1, input LED2);
  // Design side: reads the button, drives the LEDs.
  modport slave  (input BUT1, output LED1, output LED2);
endinterface

// File: rtl/top_pipe_reg.sv
// N-stage shift register with asynchronous active-low reset.
// Used for the LED1 path, the LED2 path and the optional synchronizer.
// Optional feature macro: BUT1_SYNC_EN (instantiated as synchronizer when defined).
`timescale 1ns/1ps
module pipe_reg #(
  parameter int N = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] s_q;
  logic [N-1:0] s_d;

  // Next state: every stage takes its predecessor's pre-edge value.
  always_comb begin
    s_d    = '0;
    s_d[0] = d_i;
    for (int i = 1; i < N; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  // Stage registers; reset discards everything in flight without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q_o = s_q[N-1];

endmodule

// File: rtl/top.sv
// Board-level top: samples BUT1 and drives LED1 (1-stage) and LED2
// (DEPTH-stage) from register chains; LEDs optionally active-low.
// Optional feature macro: BUT1_SYNC_EN adds a shared two-flop synchronizer
// in front of both chains (+2 cycles on both LEDs).
`timescale 1ns/1ps
module top
  import top_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT1,
  output logic LED1,
  output logic LED2
);

  localparam logic LED_ON  = led_on(LED_ACTIVE_LOW);
  localparam logic LED_OFF = led_off(LED_ACTIVE_LOW);

  // Reject an out-of-range LED2 depth at elaboration.
  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("top: DEPTH out of range");
  end

  logic b;
  logic r1_q;
  logic s_last_q;

`ifdef BUT1_SYNC_EN
  // Shared synchronizer so both chains always see the same sample.
  pipe_reg #(.N(SYNC_STAGES)) u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (BUT1),
    .q_o    (b)
  );
`else
  assign b = BUT1;
`endif

  // LED1 chain: a single register.
  pipe_reg #(.N(1)) u_led1 (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (b),
    .q_o    (r1_q)
  );

  // LED2 chain: DEPTH concurrent stages.
  pipe_reg #(.N(DEPTH)) u_led2 (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (b),
    .q_o    (s_last_q)
  );

  // Only a polarity select after each flop; no combinational path from BUT1.
  assign LED1 = r1_q     ? LED_ON : LED_OFF;
  assign LED2 = s_last_q ? LED_ON : LED_OFF;

endmodule

// File: tb/tb_top.sv
// Testbench for top: three instances (default, DEPTH=4, active-low LEDs)
// driven by a shared button/reset through top_if pin bundles.
`timescale 1ns/100ps
module tb_top;

`ifdef BUT1_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  top_if p0 ();
  top_if p4 ();
  top_if pal ();

  top #(.DEPTH(2), .LED_ACTIVE_LOW(1'b0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .BUT1(p0.BUT1), .LED1(p0.LED1), .LED2(p0.LED2));
  top #(.DEPTH(4), .LED_ACTIVE_LOW(1'b0)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .BUT1(p4.BUT1), .LED1(p4.LED1), .LED2(p4.LED2));
  top #(.DEPTH(2), .LED_ACTIVE_LOW(1'b1)) u_dutal (
    .CLK(clk), .RST_N(rst_n), .BUT1(pal.BUT1), .LED1(pal.LED1), .LED2(pal.LED2));

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct packed {
    logic rst_n;
    logic but;
    logic l1;   // expected LED1 (all instances, active-high view)
    logic l2;   // expected LED2, DEPTH=2
    logic l4;   // expected LED2, DEPTH=4
  } vec_t;

  vec_t tbl [26];

  task automatic set_but(input logic v);
    p0.BUT1  = v;
    p4.BUT1  = v;
    pal.BUT1 = v;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int lat1, lat2, lat4, w1, w4;

    // Reset 5 cycles with button held, then release and pulse patterns.
    for (int k = 0; k < 5; k++) tbl[k] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // One-in-five periodic pulse.
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // Two-cycle pulse keeps its width on every LED.
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b1;
    set_but(1'b0);
    #0.2 rst_n = 1'b0;

    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      rst_n = tbl[k].rst_n;
      set_but(tbl[k].but);
      @(posedge clk);
      #0.5;
`ifndef BUT1_SYNC_EN
      chk($sformatf("v%0d_led1", k),    p0.LED1,  tbl[k].l1);
      chk($sformatf("v%0d_led2", k),    p0.LED2,  tbl[k].l2);
      chk($sformatf("v%0d_d4_led2", k), p4.LED2,  tbl[k].l4);
      chk($sformatf("v%0d_al_led1", k), pal.LED1, ~tbl[k].l1);
      chk($sformatf("v%0d_al_led2", k), pal.LED2, ~tbl[k].l2);
`endif
    end

    // Single-cycle pulse: measure latency and width on each chain.
    lat1 = -1; lat2 = -1; lat4 = -1; w1 = 0; w4 = 0;
    @(negedge clk);
    set_but(1'b1);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #0.5;
      if (p0.LED1 === 1'b1) begin
        w1++;
        if (lat1 < 0) lat1 = e;
      end
      if (p0.LED2 === 1'b1 && lat2 < 0) lat2 = e;
      if (p4.LED2 === 1'b1) begin
        w4++;
        if (lat4 < 0) lat4 = e;
      end
      @(negedge clk);
      set_but(1'b0);
    end
    chk_int("lat_led1",    lat1, 1 + LAT);
    chk_int("lat_led2",    lat2, 2 + LAT);
    chk_int("lat_d4_led2", lat4, 4 + LAT);
    chk_int("lag_d4",      lat4 - lat1, 3);
    chk_int("width_led1",  w1, 1);
    chk_int("width_d4",    w4, 1);

    // Mid-operation reset: pulse sitting in the first stage is discarded.
    @(negedge clk);
    set_but(1'b1);
    @(posedge clk);
    #0.5;
    chk("mid_pre_led1", p0.LED1, (LAT == 0) ? 1'b1 : 1'b0);
    rst_n = 1'b0;
    #0.2;
    chk("mid_rst_led1",    p0.LED1,  1'b0);
    chk("mid_rst_led2",    p0.LED2,  1'b0);
    chk("mid_rst_al_led1", pal.LED1, 1'b1);
    chk("mid_rst_d4_led1", p4.LED1,  1'b0);
    @(negedge clk);
    set_but(1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #0.5;
      chk($sformatf("post_rst%0d_led1", e),    p0.LED1,  1'b0);
      chk($sformatf("post_rst%0d_led2", e),    p0.LED2,  1'b0);
      chk($sformatf("post_rst%0d_d4_led2", e), p4.LED2,  1'b0);
      chk($sformatf("post_rst%0d_al_led2", e), pal.LED2, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #5000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
